// File: rtl/host_rx_stage_controller.sv
// Bring-up stage sequencer for the host receive path. Stage changes are
// committed only inside inter-frame gaps long enough to drain the selector delay.
module host_rx_stage_controller #(
  parameter int unsigned P_GUARD        = 14,
  parameter logic [31:0] P_SYNC_TIMEOUT = 32'd1250000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_bufid_init_done,
  input  logic        i_cfg_finish,
  input  logic        i_sync_finish,
  input  logic        i_sync_pulse,
  input  logic [8:0]  iv_data,
  input  logic        i_data_wr,
  output logic        o_hardware_initial_finish,
  output logic        o_rc_rxenable,
  output logic        o_st_rxenable,
  output logic [1:0]  ov_stage,
  output logic        o_transition_pending,
  output logic [15:0] ov_sync_loss_cnt
);

  localparam int unsigned IDLE_W = (P_GUARD < 1) ? 1 : $clog2(P_GUARD + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(P_GUARD);

  typedef enum logic [1:0] {
    STG_INIT = 2'd0,
    STG_CFG  = 2'd1,
    STG_RC   = 2'd2,
    STG_ST   = 2'd3
  } stage_e;

  stage_e             stage_r;
  stage_e             target_s;
  stage_e             stage_nxt_s;
  logic               commit_s;
  logic               mark_s;
  logic               in_frame_r;
  logic [IDLE_W-1:0]  idle_cnt_r;
  logic [IDLE_W-1:0]  idle_now_s;
  logic               guard_ok_s;
  logic [31:0]        wd_cnt_r;
  logic [31:0]        wd_nxt_s;
  logic               timeout_s;
  logic               sync_lost_r;
  logic               hw_fin_r;
  logic               rc_en_r;
  logic               st_en_r;
  logic               pending_r;
  logic [15:0]        loss_cnt_r;

  // Idle count includes the current cycle, so guard_ok means P_GUARD quiet cycles up to and including now
  always_comb begin
    mark_s = i_data_wr & iv_data[8];
    if (in_frame_r || mark_s) begin
      idle_now_s = '0;
    end else if (idle_cnt_r >= IDLE_MAX) begin
      idle_now_s = IDLE_MAX;
    end else begin
      idle_now_s = idle_cnt_r + IDLE_W'(1);
    end
    guard_ok_s = (idle_now_s == IDLE_MAX) && !mark_s;
  end

  // Frame tracking and idle counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      in_frame_r <= 1'b0;
      idle_cnt_r <= IDLE_MAX;
    end else begin
      if (mark_s) begin
        in_frame_r <= ~in_frame_r;
      end else begin
        in_frame_r <= in_frame_r;
      end
      idle_cnt_r <= idle_now_s;
    end
  end

  // Target stage selection and guarded commit
  always_comb begin
    target_s    = stage_r;
    stage_nxt_s = stage_r;
    case (stage_r)
      STG_INIT: begin
        if (i_bufid_init_done) target_s = STG_CFG;
        else                   target_s = STG_INIT;
      end
      STG_CFG: begin
        if (i_cfg_finish) target_s = STG_RC;
        else              target_s = STG_CFG;
      end
      STG_RC: begin
        if (!i_cfg_finish)                      target_s = STG_CFG;
        else if (i_sync_finish && !sync_lost_r) target_s = STG_ST;
        else                                    target_s = STG_RC;
      end
      STG_ST: begin
        if (!i_cfg_finish)                      target_s = STG_CFG;
        else if (!i_sync_finish || sync_lost_r) target_s = STG_RC;
        else                                    target_s = STG_ST;
      end
      default: target_s = STG_INIT;
    endcase
    commit_s = (target_s != stage_r) && guard_ok_s;
    if (commit_s) begin
      stage_nxt_s = target_s;
    end else begin
      stage_nxt_s = stage_r;
    end
  end

  // Stage register and the enables derived from the committed stage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage_r   <= STG_INIT;
      hw_fin_r  <= 1'b0;
      rc_en_r   <= 1'b0;
      st_en_r   <= 1'b0;
      pending_r <= 1'b0;
    end else begin
      stage_r   <= stage_nxt_s;
      hw_fin_r  <= (stage_nxt_s != STG_INIT);
      rc_en_r   <= (stage_nxt_s == STG_RC) || (stage_nxt_s == STG_ST);
      st_en_r   <= (stage_nxt_s == STG_ST);
      pending_r <= (target_s != stage_r) && !commit_s;
    end
  end

  // Watchdog: a pulse coinciding with the timeout suppresses it; held at zero until demotion
  always_comb begin
    timeout_s = (stage_r == STG_ST) && !sync_lost_r && !i_sync_pulse &&
                (wd_cnt_r == (P_SYNC_TIMEOUT - 32'd1));
    if (stage_r != STG_ST) begin
      wd_nxt_s = 32'd0;
    end else if (i_sync_pulse || sync_lost_r || timeout_s) begin
      wd_nxt_s = 32'd0;
    end else begin
      wd_nxt_s = wd_cnt_r + 32'd1;
    end
  end

  // Watchdog counter, sync-lost flag and saturating loss counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wd_cnt_r    <= 32'd0;
      sync_lost_r <= 1'b0;
      loss_cnt_r  <= 16'd0;
    end else begin
      wd_cnt_r <= wd_nxt_s;
      if (i_sync_pulse) begin
        sync_lost_r <= 1'b0;
      end else if (timeout_s) begin
        sync_lost_r <= 1'b1;
      end else begin
        sync_lost_r <= sync_lost_r;
      end
      if (timeout_s && (loss_cnt_r != 16'hFFFF)) begin
        loss_cnt_r <= loss_cnt_r + 16'd1;
      end else begin
        loss_cnt_r <= loss_cnt_r;
      end
    end
  end

  assign o_hardware_initial_finish = hw_fin_r;
  assign o_rc_rxenable             = rc_en_r;
  assign o_st_rxenable             = st_en_r;
  assign ov_stage                  = stage_r;
  assign o_transition_pending      = pending_r;
  assign ov_sync_loss_cnt          = loss_cnt_r;

endmodule

// File: tb/tb_host_rx_stage_controller.sv
// Directed bench for host_rx_stage_controller: stage sequencing, frame guard,
// watchdog demotion and asynchronous reset, with hand-derived expectations.
module tb_host_rx_stage_controller;

  logic        clk;
  logic        rst_n;
  logic        bufid_init_done;
  logic        cfg_finish;
  logic        sync_finish;
  logic        sync_pulse;
  logic [8:0]  data;
  logic        data_wr;
  logic        hw_fin;
  logic        rc_en;
  logic        st_en;
  logic [1:0]  stage;
  logic        pending;
  logic [15:0] loss_cnt;

  int total = 0;
  int bad   = 0;

  host_rx_stage_controller #(
    .P_GUARD        (14),
    .P_SYNC_TIMEOUT (32'd100)
  ) dut (
    .i_clk                     (clk),
    .i_rst_n                   (rst_n),
    .i_bufid_init_done         (bufid_init_done),
    .i_cfg_finish              (cfg_finish),
    .i_sync_finish             (sync_finish),
    .i_sync_pulse              (sync_pulse),
    .iv_data                   (data),
    .i_data_wr                 (data_wr),
    .o_hardware_initial_finish (hw_fin),
    .o_rc_rxenable             (rc_en),
    .o_st_rxenable             (st_en),
    .ov_stage                  (stage),
    .o_transition_pending      (pending),
    .ov_sync_loss_cnt          (loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] stg, input logic hw,
                          input logic rc, input logic st);
    chk({tag, ".stage"}, 32'(stage), 32'(stg));
    chk({tag, ".hw"},    32'(hw_fin), 32'(hw));
    chk({tag, ".rc"},    32'(rc_en), 32'(rc));
    chk({tag, ".st"},    32'(st_en), 32'(st));
  endtask

  task automatic wr(input logic [8:0] d);
    data    = d;
    data_wr = 1'b1;
    tick();
    data_wr = 1'b0;
    data    = 9'h000;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    bufid_init_done = 1'b0;
    cfg_finish = 1'b0;
    sync_finish = 1'b0;
    sync_pulse = 1'b0;
    data = 9'h000;
    data_wr = 1'b0;
    idle(2);
    chk_outs("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    chk("reset.pending", 32'(pending), 32'd0);
    chk("reset.loss", 32'(loss_cnt), 32'd0);
    rst_n = 1'b1;
    idle(3);
    chk_outs("init_hold", 2'd0, 1'b0, 1'b0, 1'b0);

    // Bring-up: each raise commits on the next edge because the link is idle
    bufid_init_done = 1'b1; tick();
    chk_outs("to_cfg", 2'd1, 1'b1, 1'b0, 1'b0);
    chk("to_cfg.pending", 32'(pending), 32'd0);
    cfg_finish = 1'b1; tick();
    chk_outs("to_rc", 2'd2, 1'b1, 1'b1, 1'b0);
    sync_finish = 1'b1; tick();
    chk_outs("to_st", 2'd3, 1'b1, 1'b1, 1'b1);

    // Watchdog: counter is 99 after 99 edges in ST, timeout taken on the 100th
    idle(99);
    chk("wd.before", 32'(loss_cnt), 32'd0);
    tick();
    chk("wd.loss", 32'(loss_cnt), 32'd1);
    chk("wd.still_st", 32'(stage), 32'd3);
    tick();
    chk_outs("wd.demote", 2'd2, 1'b1, 1'b1, 1'b0);
    sync_pulse = 1'b1; tick(); sync_pulse = 1'b0;
    chk("wd.pulse_edge", 32'(stage), 32'd2);
    tick();
    chk_outs("wd.repromote", 2'd3, 1'b1, 1'b1, 1'b1);
    idle(99);
    sync_pulse = 1'b1; tick(); sync_pulse = 1'b0;
    chk("wd.tie_loss", 32'(loss_cnt), 32'd1);
    chk("wd.tie_stage", 32'(stage), 32'd3);
    idle(3);
    chk("wd.after_tie", 32'(stage), 32'd3);

    // Reconfiguration skips straight to CFG, then climbs one step per commit
    cfg_finish = 1'b0; tick();
    chk_outs("recfg", 2'd1, 1'b1, 1'b0, 1'b0);
    cfg_finish = 1'b1; tick();
    chk_outs("recfg.rc", 2'd2, 1'b1, 1'b1, 1'b0);
    tick();
    chk_outs("recfg.st", 2'd3, 1'b1, 1'b1, 1'b1);
    sync_finish = 1'b0; tick();
    chk("rc_again", 32'(stage), 32'd2);

    // Long frame in RC: sync raised mid-frame, commit after 14 idle cycles past tail
    wr(9'h100);
    for (int i = 1; i <= 62; i++) begin
      if (i == 20) sync_finish = 1'b1;
      wr(9'(i));
      if (i == 20) chk("frame.pending", 32'(pending), 32'd1);
      if (i == 40) chk("frame.mid_stage", 32'(stage), 32'd2);
    end
    wr(9'h100);
    idle(13);
    chk("frame.guard13", 32'(stage), 32'd2);
    chk("frame.guard13_pend", 32'(pending), 32'd1);
    tick();
    chk_outs("frame.commit", 2'd3, 1'b1, 1'b1, 1'b1);
    chk("frame.commit_pend", 32'(pending), 32'd0);

    // Back to RC, then 10-cycle gaps never satisfy the 14-cycle guard
    sync_finish = 1'b0; tick();
    chk("gap.rc", 32'(stage), 32'd2);
    sync_finish = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wr(9'h155);
      for (int j = 0; j < 3; j++) wr(9'h02A);
      wr(9'h155);
      idle(10);
      chk("gap.held_stage", 32'(stage), 32'd2);
      chk("gap.held_pend", 32'(pending), 32'd1);
    end
    wr(9'h155);
    for (int j = 0; j < 3; j++) wr(9'h02A);
    wr(9'h155);
    idle(13);
    chk("gap14.before", 32'(stage), 32'd2);
    tick();
    chk("gap14.commit", 32'(stage), 32'd3);

    // A marked write in a cycle that would otherwise pass the guard blocks the commit
    sync_finish = 1'b0;
    wr(9'h100);
    chk("block.stage", 32'(stage), 32'd3);
    chk("block.pend", 32'(pending), 32'd1);
    wr(9'h100);
    idle(13);
    chk("block.guard13", 32'(stage), 32'd3);
    tick();
    chk_outs("block.commit", 2'd2, 1'b1, 1'b1, 1'b0);

    // Reverted condition cancels the pending change
    wr(9'h100);
    wr(9'h011);
    sync_finish = 1'b1;
    wr(9'h012);
    chk("cancel.pend1", 32'(pending), 32'd1);
    sync_finish = 1'b0;
    wr(9'h013);
    chk("cancel.pend0", 32'(pending), 32'd0);
    wr(9'h100);
    idle(20);
    chk("cancel.stage", 32'(stage), 32'd2);
    chk("cancel.pend_end", 32'(pending), 32'd0);

    // Asynchronous reset mid-frame while in ST
    sync_finish = 1'b1; tick();
    chk("pre_rst.st", 32'(stage), 32'd3);
    wr(9'h100);
    wr(9'h0F0);
    #2 rst_n = 1'b0;
    #1;
    chk_outs("async_rst", 2'd0, 1'b0, 1'b0, 1'b0);
    chk("async_rst.loss", 32'(loss_cnt), 32'd0);
    chk("async_rst.pend", 32'(pending), 32'd0);
    cfg_finish = 1'b0;
    sync_finish = 1'b0;
    bufid_init_done = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk_outs("post_rst.cfg", 2'd1, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
